// File: rtl/bist_signature_unit_if.sv
// Strobe/response bundle between the BIST controller side and the signature unit.
interface bist_signature_unit_if #(
    parameter int unsigned PW = 8,
    parameter int unsigned SW = 16
);
    logic          init;
    logic          running;
    logic          toggle;
    logic          finish;
    logic [SW-1:0] cut_out;
    logic [PW-1:0] pattern_out;
    logic [SW-1:0] signature;
    logic [15:0]   sample_cnt;
    logic          result_valid;
    logic          pass;
    logic          fail;

    modport master (
        output init, running, toggle, finish, cut_out,
        input  pattern_out, signature, sample_cnt, result_valid, pass, fail
    );

    modport slave (
        input  init, running, toggle, finish, cut_out,
        output pattern_out, signature, sample_cnt, result_valid, pass, fail
    );
endinterface

// File: rtl/bist_signature_unit.sv
// BIST stimulus generator (Galois LFSR) and response compactor (MISR) with
// end-of-test golden-signature compare.
module bist_signature_unit #(
    parameter int unsigned       PW        = 8,
    parameter logic [PW-1:0]     LFSR_POLY = 8'h1D,
    parameter logic [PW-1:0]     SEED      = 8'h01,
    parameter int unsigned       SW        = 16,
    parameter logic [SW-1:0]     MISR_POLY = 16'h1021,
    parameter logic [SW-1:0]     GOLDEN    = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    bist_signature_unit_if.slave  bus
);
    localparam int unsigned CW = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        r_state, w_state_n;
    logic [PW-1:0] r_lfsr,  w_lfsr_n;
    logic [SW-1:0] r_sig,   w_sig_n;
    logic [CW-1:0] r_cnt,   w_cnt_n;
    logic          r_valid, w_valid_n;
    logic          r_pass,  w_pass_n;
    logic          r_fail,  w_fail_n;
    logic          w_capture;

    function automatic logic [PW-1:0] lfsr_step(input logic [PW-1:0] v);
        return {v[PW-2:0], 1'b0} ^ (v[PW-1] ? LFSR_POLY : PW'(0));
    endfunction

    function automatic logic [SW-1:0] misr_step(input logic [SW-1:0] s,
                                                 input logic [SW-1:0] d);
        return {s[SW-2:0], 1'b0} ^ (s[SW-1] ? MISR_POLY : SW'(0)) ^ d;
    endfunction

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_lfsr  <= SEED;
            r_sig   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_lfsr  <= w_lfsr_n;
            r_sig   <= w_sig_n;
            r_cnt   <= w_cnt_n;
            r_valid <= w_valid_n;
            r_pass  <= w_pass_n;
            r_fail  <= w_fail_n;
        end
    end

    // Next-state and datapath update; init overrides everything
    always_comb begin
        w_state_n = r_state;
        w_lfsr_n  = r_lfsr;
        w_sig_n   = r_sig;
        w_cnt_n   = r_cnt;
        w_valid_n = r_valid;
        w_pass_n  = r_pass;
        w_fail_n  = r_fail;
        w_capture = bus.running && (r_state == S_ARMED || r_state == S_RUN);

        if (bus.init) begin
            w_state_n = S_ARMED;
            w_lfsr_n  = SEED;
            w_sig_n   = '0;
            w_cnt_n   = '0;
            w_valid_n = 1'b0;
            w_pass_n  = 1'b0;
            w_fail_n  = 1'b0;
        end else begin
            case (r_state)
                S_ARMED, S_RUN: begin
                    if (w_capture) begin
                        w_lfsr_n  = lfsr_step(r_lfsr);
                        w_sig_n   = misr_step(r_sig, bus.cut_out);
                        w_cnt_n   = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);
                        w_state_n = S_RUN;
                    end
                    if (bus.finish) begin
                        w_state_n = S_CHECK;
                    end
                end
                S_CHECK: begin
                    w_valid_n = 1'b1;
                    w_pass_n  = (r_sig == GOLDEN);
                    w_fail_n  = (r_sig != GOLDEN);
                    w_state_n = S_DONE;
                end
                default: ;
            endcase
        end
    end

    assign bus.pattern_out  = bus.toggle ? ~r_lfsr : r_lfsr;
    assign bus.signature    = r_sig;
    assign bus.sample_cnt   = r_cnt;
    assign bus.result_valid = r_valid;
    assign bus.pass         = r_pass;
    assign bus.fail         = r_fail;
endmodule

// File: tb/tb_bist_signature_unit.sv
// Self-checking bench: directed vector table, reset sequences and randomized
// traffic against an arithmetic reference model.
module tb_bist_signature_unit;
    localparam int PW    = 4;
    localparam int SW    = 4;
    localparam int LPOLY = 3;
    localparam int SEEDV = 1;
    localparam int MPOLY = 3;
    localparam int GOLD  = 12;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;

    bist_signature_unit_if #(.PW(PW), .SW(SW)) bif ();

    bist_signature_unit #(
        .PW(PW), .LFSR_POLY(4'h3), .SEED(4'h1),
        .SW(SW), .MISR_POLY(4'h3), .GOLDEN(4'hC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    // Reference model: values as plain integers, polynomial arithmetic mod 2^W
    int m_lfsr, m_sig, m_cnt;
    bit m_active, m_checking, m_valid, m_pass, m_fail;

    function automatic int poly_x(input int v, input int w, input int poly);
        int r;
        r = v * 2;
        if (r >= (1 << w)) r = (r - (1 << w)) ^ poly;
        return r;
    endfunction

    task automatic model_reset();
        m_lfsr = SEEDV; m_sig = 0; m_cnt = 0;
        m_active = 0; m_checking = 0;
        m_valid = 0; m_pass = 0; m_fail = 0;
    endtask

    task automatic model_edge();
        if (bif.init) begin
            model_reset();
            m_active = 1;
        end else if (m_active) begin
            if (bif.running) begin
                m_lfsr = poly_x(m_lfsr, PW, LPOLY);
                m_sig  = poly_x(m_sig, SW, MPOLY) ^ int'(bif.cut_out);
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end
            if (bif.finish) begin
                m_active = 0;
                m_checking = 1;
            end
        end else if (m_checking) begin
            m_checking = 0;
            m_valid = 1;
            m_pass = (m_sig == GOLD);
            m_fail = !m_pass;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int pat;
        pat = bif.toggle ? ((~m_lfsr) & ((1 << PW) - 1)) : m_lfsr;
        check({tag, ".pattern"}, int'(bif.pattern_out), pat);
        check({tag, ".signature"}, int'(bif.signature), m_sig);
        check({tag, ".sample_cnt"}, int'(bif.sample_cnt), m_cnt);
        check({tag, ".valid"}, int'(bif.result_valid), int'(m_valid));
        check({tag, ".pass"}, int'(bif.pass), int'(m_pass));
        check({tag, ".fail"}, int'(bif.fail), int'(m_fail));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit i, input bit r, input bit t, input bit f, input int c);
        bif.init = i; bif.running = r; bif.toggle = t; bif.finish = f;
        bif.cut_out = SW'(c);
    endtask

    typedef struct {
        bit i, r, t, f;
        int cut;
        int pat, sig, cnt;
        bit v, p, fl;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit i, bit r, bit t, bit f, int cut,
                                int pat, int sig, int cnt, bit v, bit p, bit fl);
        vec_t x;
        x.i = i; x.r = r; x.t = t; x.f = f; x.cut = cut;
        x.pat = pat; x.sig = sig; x.cnt = cnt; x.v = v; x.p = p; x.fl = fl;
        return x;
    endfunction

    initial begin
        n_checks = 0;
        n_fails = 0;
        model_reset();

        //            i  r  t  f cut  pat  sig cnt v  p  f
        tbl.push_back(mk(1, 0, 0, 0, 1, 'h1, 'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 'h2, 'h1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 'h4, 'h3, 2, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 'h8, 'h7, 3, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 'h3, 'hF, 4, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 'h6, 'hC, 5, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 'h6, 'hC, 5, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 'h6, 'hC, 5, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 'h6, 'hC, 5, 1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 'h9, 'hC, 5, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 'h1, 'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 'hE, 'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 'h2, 'h1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 'h4, 'h3, 2, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 'h8, 'h7, 3, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 'h3, 'hF, 4, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 'h6, 'hC, 5, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 'hC, 'hA, 6, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 'hB, 'h6, 7, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 'hB, 'h6, 7, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 'hB, 'h6, 7, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 'h1, 'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 'h2, 'h1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 'h4, 'h3, 2, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 'h8, 'h7, 3, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 'h1, 'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 'h1, 'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 'h1, 'h0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 'h1, 'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 'h2, 'h1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 'h2, 'h1, 1, 1, 0, 1));

        // Reset held low with the clock running, then released without init
        drive(0, 1, 0, 0, 5);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_model("reset_hold");
        end
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check_model("no_init");
        end

        // Directed table
        foreach (tbl[k]) begin
            drive(tbl[k].i, tbl[k].r, tbl[k].t, tbl[k].f, tbl[k].cut);
            tick();
            check($sformatf("vec%0d.pattern", k), int'(bif.pattern_out), tbl[k].pat);
            check($sformatf("vec%0d.signature", k), int'(bif.signature), tbl[k].sig);
            check($sformatf("vec%0d.sample_cnt", k), int'(bif.sample_cnt), tbl[k].cnt);
            check($sformatf("vec%0d.valid", k), int'(bif.result_valid), int'(tbl[k].v));
            check($sformatf("vec%0d.pass", k), int'(bif.pass), int'(tbl[k].p));
            check($sformatf("vec%0d.fail", k), int'(bif.fail), int'(tbl[k].fl));
        end

        // Asynchronous reset between edges in the middle of a run
        drive(1, 0, 0, 0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 0, int'($urandom_range(0, 15)));
            tick();
            check_model("pre_abort");
        end
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        check_model("async_reset");
        @(posedge clk);
        #1;
        check_model("async_reset_held");
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check_model("post_reset_no_capture");
        end

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 11) == 0,
                  int'($urandom_range(0, 15)));
            tick();
            check_model("random");
            check("random.pass_and_fail", int'(bif.pass && bif.fail), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
